pc8001_keymatrix: RTL and testbench

PC8001_KEYMATRIX -- requirements
Module: pc8001_keymatrix

---
 rtl/pc8001_kbd_pkg.sv | 47 ++++
 rtl/pc8001_keymap.sv | 111 +++++++++++
 rtl/pc8001_keymatrix.sv | 149 ++++++++++++++
 tb/tb_pc8001_keymatrix.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/pc8001_kbd_pkg.sv
// Shared types and constants for the PC-8001 keyboard matrix: FSM states,
// matrix geometry, special-key positions and the keymap lookup record.
package pc8001_kbd_pkg;

  localparam int NUM_ROWS = 10;

  localparam int ROW_SHIFT = 8;
  localparam int BIT_SHIFT = 6;
  localparam int ROW_CTRL  = 8;
  localparam int BIT_CTRL  = 7;
  localparam int ROW_GRPH  = 8;
  localparam int BIT_GRPH  = 4;
  localparam int ROW_KANA  = 8;
  localparam int BIT_KANA  = 5;
  localparam int ROW_STOP  = 9;
  localparam int BIT_STOP  = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOOK  = 2'd1,
    ST_APPLY = 2'd2
  } state_t;

  // Field order matches ps2_key[9:0] so the raw bus casts straight in.
  typedef struct packed {
    logic       pressed;
    logic       ext;
    logic [7:0] code;
  } kev_t;

  typedef struct packed {
    logic       valid;
    logic [3:0] row;
    logic [2:0] col;
    logic       synth_shift;
  } keymap_t;

  function automatic keymap_t mk(input int r, input int c, input logic s);
    keymap_t m;
    m.valid       = 1'b1;
    m.row         = r[3:0];
    m.col         = c[2:0];
    m.synth_shift = s;
    return m;
  endfunction

endpackage

// File: rtl/pc8001_keymap.sv
// PS/2 set-2 scancode (with E0 flag) to PC-8001 matrix position lookup.
module pc8001_keymap
  import pc8001_kbd_pkg::*;
(
  input  logic [7:0] i_code,
  input  logic       i_ext,
  output keymap_t    o_map
);

  always_comb begin
    o_map = '0;
    case ({i_ext, i_code})
      // numeric keypad 0-7
      9'h070: o_map = mk(0, 0, 1'b0);
      9'h069: o_map = mk(0, 1, 1'b0);
      9'h072: o_map = mk(0, 2, 1'b0);
      9'h07A: o_map = mk(0, 3, 1'b0);
      9'h06B: o_map = mk(0, 4, 1'b0);
      9'h073: o_map = mk(0, 5, 1'b0);
      9'h074: o_map = mk(0, 6, 1'b0);
      9'h06C: o_map = mk(0, 7, 1'b0);
      // keypad 8 9 * + . and both RETURN keys
      9'h075: o_map = mk(1, 0, 1'b0);
      9'h07D: o_map = mk(1, 1, 1'b0);
      9'h07C: o_map = mk(1, 2, 1'b0);
      9'h079: o_map = mk(1, 3, 1'b0);
      9'h071: o_map = mk(1, 6, 1'b0);
      9'h05A: o_map = mk(1, 7, 1'b0);
      9'h15A: o_map = mk(1, 7, 1'b0);
      // @ A-G
      9'h00E: o_map = mk(2, 0, 1'b0);
      9'h01C: o_map = mk(2, 1, 1'b0);
      9'h032: o_map = mk(2, 2, 1'b0);
      9'h021: o_map = mk(2, 3, 1'b0);
      9'h023: o_map = mk(2, 4, 1'b0);
      9'h024: o_map = mk(2, 5, 1'b0);
      9'h02B: o_map = mk(2, 6, 1'b0);
      9'h034: o_map = mk(2, 7, 1'b0);
      // H-O
      9'h033: o_map = mk(3, 0, 1'b0);
      9'h043: o_map = mk(3, 1, 1'b0);
      9'h03B: o_map = mk(3, 2, 1'b0);
      9'h042: o_map = mk(3, 3, 1'b0);
      9'h04B: o_map = mk(3, 4, 1'b0);
      9'h03A: o_map = mk(3, 5, 1'b0);
      9'h031: o_map = mk(3, 6, 1'b0);
      9'h044: o_map = mk(3, 7, 1'b0);
      // P-W
      9'h04D: o_map = mk(4, 0, 1'b0);
      9'h015: o_map = mk(4, 1, 1'b0);
      9'h02D: o_map = mk(4, 2, 1'b0);
      9'h01B: o_map = mk(4, 3, 1'b0);
      9'h02C: o_map = mk(4, 4, 1'b0);
      9'h03C: o_map = mk(4, 5, 1'b0);
      9'h02A: o_map = mk(4, 6, 1'b0);
      9'h01D: o_map = mk(4, 7, 1'b0);
      // X Y Z [ \ ] ^ -
      9'h022: o_map = mk(5, 0, 1'b0);
      9'h035: o_map = mk(5, 1, 1'b0);
      9'h01A: o_map = mk(5, 2, 1'b0);
      9'h054: o_map = mk(5, 3, 1'b0);
      9'h05D: o_map = mk(5, 4, 1'b0);
      9'h05B: o_map = mk(5, 5, 1'b0);
      9'h055: o_map = mk(5, 6, 1'b0);
      9'h04E: o_map = mk(5, 7, 1'b0);
      // 0-7
      9'h045: o_map = mk(6, 0, 1'b0);
      9'h016: o_map = mk(6, 1, 1'b0);
      9'h01E: o_map = mk(6, 2, 1'b0);
      9'h026: o_map = mk(6, 3, 1'b0);
      9'h025: o_map = mk(6, 4, 1'b0);
      9'h02E: o_map = mk(6, 5, 1'b0);
      9'h036: o_map = mk(6, 6, 1'b0);
      9'h03D: o_map = mk(6, 7, 1'b0);
      // 8 9 : ; , . / _
      9'h03E: o_map = mk(7, 0, 1'b0);
      9'h046: o_map = mk(7, 1, 1'b0);
      9'h052: o_map = mk(7, 2, 1'b0);
      9'h04C: o_map = mk(7, 3, 1'b0);
      9'h041: o_map = mk(7, 4, 1'b0);
      9'h049: o_map = mk(7, 5, 1'b0);
      9'h04A: o_map = mk(7, 6, 1'b0);
      9'h051: o_map = mk(7, 7, 1'b0);
      // cursor/edit keys; left and down reuse right and up plus shift
      9'h16C: o_map = mk(8, 0, 1'b0);
      9'h175: o_map = mk(8, 1, 1'b0);
      9'h174: o_map = mk(8, 2, 1'b0);
      9'h16B: o_map = mk(8, 2, 1'b1);
      9'h172: o_map = mk(8, 1, 1'b1);
      9'h066: o_map = mk(8, 3, 1'b0);
      9'h171: o_map = mk(8, 3, 1'b0);
      9'h011: o_map = mk(ROW_GRPH, BIT_GRPH, 1'b0);
      9'h111: o_map = mk(ROW_KANA, BIT_KANA, 1'b0);
      9'h012: o_map = mk(ROW_SHIFT, BIT_SHIFT, 1'b0);
      9'h059: o_map = mk(ROW_SHIFT, BIT_SHIFT, 1'b0);
      9'h014: o_map = mk(ROW_CTRL, BIT_CTRL, 1'b0);
      9'h114: o_map = mk(ROW_CTRL, BIT_CTRL, 1'b0);
      // STOP(F10) F1-F5 SPACE ESC
      9'h009: o_map = mk(ROW_STOP, BIT_STOP, 1'b0);
      9'h005: o_map = mk(9, 1, 1'b0);
      9'h006: o_map = mk(9, 2, 1'b0);
      9'h004: o_map = mk(9, 3, 1'b0);
      9'h00C: o_map = mk(9, 4, 1'b0);
      9'h003: o_map = mk(9, 5, 1'b0);
      9'h029: o_map = mk(9, 6, 1'b0);
      9'h076: o_map = mk(9, 7, 1'b0);
      default: o_map = '0;
    endcase
  end

endmodule

// File: rtl/pc8001_keymatrix.sv
// PS/2 event to PC-8001 10x8 keyboard matrix, with a one-deep pending buffer
// and shift merging (left/right shift keys plus cursor-synthesised shift).
module pc8001_keymatrix
  import pc8001_kbd_pkg::*;
(
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [10:0] ps2_key,
  input  logic        all_release,
  input  logic [3:0]  row_sel,
  output logic [7:0]  row_data,
  output logic        stop_key,
  output logic        kbd_overflow,
  output logic        busy
);

  state_t                        r_state, w_next;
  logic                          r_tog;
  kev_t                          r_cur, r_pend;
  logic                          r_pend_vld;
  keymap_t                       r_map;
  logic                          r_press, r_is_lsh, r_is_rsh;
  logic                          r_lsh, r_rsh, r_synth;
  logic [NUM_ROWS-1:0][7:0]      r_mat;
  logic [NUM_ROWS-1:0][7:0]      w_rows;
  logic [7:0]                    r_row_data;
  logic                          r_ovf;
  logic                          w_evt, w_take_evt, w_take_pend, w_apply;
  kev_t                          w_kev;
  keymap_t                       w_map;

  assign w_evt   = ps2_key[10] ^ r_tog;
  assign w_kev   = kev_t'(ps2_key[9:0]);
  assign w_apply = (r_state == ST_APPLY) && !all_release;

  pc8001_keymap u_keymap (
    .i_code (r_cur.code),
    .i_ext  (r_cur.ext),
    .o_map  (w_map)
  );

  always_comb begin
    w_next      = r_state;
    w_take_evt  = 1'b0;
    w_take_pend = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_pend_vld) begin
          w_next      = ST_LOOK;
          w_take_pend = 1'b1;
        end else if (w_evt) begin
          w_next     = ST_LOOK;
          w_take_evt = 1'b1;
        end
      end
      ST_LOOK:  w_next = ST_APPLY;
      ST_APPLY: w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
    if (all_release) begin
      w_next      = ST_IDLE;
      w_take_evt  = 1'b0;
      w_take_pend = 1'b0;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_tog      <= ps2_key[10];
      r_cur      <= '0;
      r_pend     <= '0;
      r_pend_vld <= 1'b0;
      r_map      <= '0;
      r_press    <= 1'b0;
      r_is_lsh   <= 1'b0;
      r_is_rsh   <= 1'b0;
      r_lsh      <= 1'b0;
      r_rsh      <= 1'b0;
      r_synth    <= 1'b0;
      r_mat      <= '0;
      r_ovf      <= 1'b0;
    end else begin
      r_tog <= ps2_key[10];
      if (all_release) begin
        r_mat      <= '0;
        r_lsh      <= 1'b0;
        r_rsh      <= 1'b0;
        r_synth    <= 1'b0;
        r_pend_vld <= 1'b0;
      end else begin
        if (w_take_pend)     r_cur <= r_pend;
        else if (w_take_evt) r_cur <= w_kev;

        // The buffer slot frees up in the same cycle it is consumed.
        if (w_evt && !w_take_evt) begin
          if (!r_pend_vld || w_take_pend) begin
            r_pend     <= w_kev;
            r_pend_vld <= 1'b1;
          end else begin
            r_ovf <= 1'b1;
          end
        end else if (w_take_pend) begin
          r_pend_vld <= 1'b0;
        end

        if (r_state == ST_LOOK) begin
          r_map    <= w_map;
          r_press  <= r_cur.pressed;
          r_is_lsh <= !r_cur.ext && (r_cur.code == 8'h12);
          r_is_rsh <= !r_cur.ext && (r_cur.code == 8'h59);
        end

        if (w_apply) begin
          if (r_is_lsh) begin
            r_lsh <= r_press;
          end else if (r_is_rsh) begin
            r_rsh <= r_press;
          end else if (r_map.valid) begin
            for (int r = 0; r < NUM_ROWS; r++)
              if (r_map.row == 4'(r)) r_mat[r][r_map.col] <= r_press;
            if (r_map.synth_shift) r_synth <= r_press;
          end
        end
      end
    end
  end

  always_comb begin
    w_rows = r_mat;
    w_rows[ROW_SHIFT][BIT_SHIFT] = r_mat[ROW_SHIFT][BIT_SHIFT] | r_lsh | r_rsh | r_synth;
  end

  always_ff @(posedge clk_sys) begin
    if (reset)                          r_row_data <= 8'hFF;
    else if (row_sel < 4'(NUM_ROWS))    r_row_data <= ~w_rows[row_sel];
    else                                r_row_data <= 8'hFF;
  end

  assign row_data     = r_row_data;
  assign stop_key     = r_mat[ROW_STOP][BIT_STOP];
  assign kbd_overflow = r_ovf;
  assign busy         = (r_state != ST_IDLE);

endmodule

// File: tb/tb_pc8001_keymatrix.sv
// Directed bench: table of single key events plus hand-written multi-cycle cases.
module tb_pc8001_keymatrix;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic [10:0] ps2_key;
  logic        all_release;
  logic [3:0]  row_sel;
  logic [7:0]  row_data;
  logic        stop_key, kbd_overflow, busy;

  int   n_vec = 0;
  int   n_err = 0;
  logic tog   = 1'b0;

  always #5 clk_sys = ~clk_sys;

  pc8001_keymatrix dut (
    .clk_sys      (clk_sys),
    .reset        (reset),
    .ps2_key      (ps2_key),
    .all_release  (all_release),
    .row_sel      (row_sel),
    .row_data     (row_data),
    .stop_key     (stop_key),
    .kbd_overflow (kbd_overflow),
    .busy         (busy)
  );

  typedef struct {
    logic [7:0] code;
    logic       ext;
    logic       pressed;
    logic [3:0] sel;
    logic [7:0] exp;
    string      name;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] c, input logic e, input logic p);
    @(negedge clk_sys);
    tog     = ~tog;
    ps2_key = {tog, p, e, c};
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk_sys);
    @(negedge clk_sys);
  endtask

  task automatic key(input logic [7:0] c, input logic e, input logic p);
    send(c, e, p);
    cycles(5);
  endtask

  task automatic do_reset();
    @(negedge clk_sys);
    reset = 1'b1;
    cycles(2);
    reset = 1'b0;
  endtask

  initial begin
    reset       = 1'b1;
    ps2_key     = '0;
    all_release = 1'b0;
    row_sel     = 4'd0;

    vecs.push_back('{8'h1C, 1'b0, 1'b1, 4'd2, 8'hFD, "A press"});
    vecs.push_back('{8'h1C, 1'b0, 1'b1, 4'd2, 8'hFD, "A repeat"});
    vecs.push_back('{8'h1C, 1'b0, 1'b0, 4'd2, 8'hFF, "A release"});
    vecs.push_back('{8'h12, 1'b0, 1'b1, 4'd8, 8'hBF, "lshift press"});
    vecs.push_back('{8'h59, 1'b0, 1'b1, 4'd8, 8'hBF, "rshift press"});
    vecs.push_back('{8'h12, 1'b0, 1'b0, 4'd8, 8'hBF, "lshift release"});
    vecs.push_back('{8'h59, 1'b0, 1'b0, 4'd8, 8'hFF, "rshift release"});
    vecs.push_back('{8'h6B, 1'b1, 1'b1, 4'd8, 8'hBB, "left press"});
    vecs.push_back('{8'h6B, 1'b1, 1'b0, 4'd8, 8'hFF, "left release"});
    vecs.push_back('{8'h72, 1'b1, 1'b1, 4'd8, 8'hBD, "down press"});
    vecs.push_back('{8'h72, 1'b1, 1'b0, 4'd8, 8'hFF, "down release"});
    vecs.push_back('{8'h6B, 1'b0, 1'b1, 4'd0, 8'hEF, "kp4 press"});
    vecs.push_back('{8'h6B, 1'b0, 1'b0, 4'd0, 8'hFF, "kp4 release"});
    vecs.push_back('{8'h76, 1'b0, 1'b1, 4'd9, 8'h7F, "ESC press"});
    vecs.push_back('{8'h04, 1'b0, 1'b1, 4'd9, 8'h77, "F3 press"});
    vecs.push_back('{8'h76, 1'b0, 1'b0, 4'd9, 8'hF7, "ESC release"});
    vecs.push_back('{8'h04, 1'b0, 1'b0, 4'd9, 8'hFF, "F3 release"});
    vecs.push_back('{8'h07, 1'b0, 1'b1, 4'd9, 8'hFF, "unmapped F12"});
    vecs.push_back('{8'h14, 1'b0, 1'b1, 4'd8, 8'h7F, "CTRL press"});
    vecs.push_back('{8'h11, 1'b0, 1'b1, 4'd8, 8'h6F, "GRPH press"});
    vecs.push_back('{8'h11, 1'b1, 1'b1, 4'd8, 8'h4F, "KANA press"});
    vecs.push_back('{8'h14, 1'b0, 1'b0, 4'd8, 8'hCF, "CTRL release"});
    vecs.push_back('{8'h11, 1'b0, 1'b0, 4'd8, 8'hDF, "GRPH release"});
    vecs.push_back('{8'h11, 1'b1, 1'b0, 4'd8, 8'hFF, "KANA release"});
    vecs.push_back('{8'h5A, 1'b0, 1'b1, 4'd1, 8'h7F, "RETURN press"});
    vecs.push_back('{8'h16, 1'b0, 1'b1, 4'd6, 8'hFD, "1 press"});
    vecs.push_back('{8'h1A, 1'b0, 1'b1, 4'd5, 8'hFB, "Z press"});
    vecs.push_back('{8'h4A, 1'b0, 1'b1, 4'd7, 8'hBF, "/ press"});

    cycles(3);
    reset = 1'b0;
    cycles(1);

    // reset state
    for (int r = 0; r < 16; r++) begin
      row_sel = 4'(r);
      cycles(1);
      chk($sformatf("reset row %0d", r), row_data, 8'hFF);
    end
    chk("reset busy", {7'd0, busy}, 8'h00);
    chk("reset stop", {7'd0, stop_key}, 8'h00);
    chk("reset ovf", {7'd0, kbd_overflow}, 8'h00);

    // latency: not yet at 3 cycles, visible at 4
    row_sel = 4'd2;
    send(8'h1C, 1'b0, 1'b1);
    cycles(1);
    chk("busy after edge", {7'd0, busy}, 8'h01);
    cycles(2);
    chk("A at 3 cycles", row_data, 8'hFF);
    cycles(1);
    chk("A at 4 cycles", row_data, 8'hFD);
    key(8'h1C, 1'b0, 1'b0);
    chk("A released", row_data, 8'hFF);

    foreach (vecs[i]) begin
      row_sel = vecs[i].sel;
      key(vecs[i].code, vecs[i].ext, vecs[i].pressed);
      chk(vecs[i].name, row_data, vecs[i].exp);
    end
    chk("no ovf after table", {7'd0, kbd_overflow}, 8'h00);

    // all_release clears held keys (RETURN, 1, Z, /) and shift
    key(8'h12, 1'b0, 1'b1);
    @(negedge clk_sys);
    all_release = 1'b1;
    cycles(1);
    all_release = 1'b0;
    row_sel = 4'd8; cycles(1); chk("allrel row8", row_data, 8'hFF);
    row_sel = 4'd6; cycles(1); chk("allrel row6", row_data, 8'hFF);

    // all_release in APPLY cycle of SPACE press
    row_sel = 4'd9;
    send(8'h29, 1'b0, 1'b1);
    repeat (2) @(posedge clk_sys);
    @(negedge clk_sys);
    all_release = 1'b1;
    cycles(1);
    all_release = 1'b0;
    chk("apply-allrel busy", {7'd0, busy}, 8'h00);
    chk("apply-allrel row9", row_data, 8'hFF);
    cycles(3);
    chk("apply-allrel row9 later", row_data, 8'hFF);

    // event coincident with all_release is discarded, no overflow
    row_sel = 4'd2;
    send(8'h32, 1'b0, 1'b1);
    all_release = 1'b1;
    cycles(1);
    all_release = 1'b0;
    cycles(5);
    chk("allrel drop row2", row_data, 8'hFF);
    chk("allrel drop ovf", {7'd0, kbd_overflow}, 8'h00);

    // reset mid-operation abandons the event
    row_sel = 4'd4;
    send(8'h15, 1'b0, 1'b1);
    @(posedge clk_sys);
    @(negedge clk_sys);
    reset = 1'b1;
    cycles(1);
    reset = 1'b0;
    cycles(5);
    chk("midreset row4", row_data, 8'hFF);
    chk("midreset busy", {7'd0, busy}, 8'h00);

    // STOP key
    row_sel = 4'd9;
    key(8'h09, 1'b0, 1'b1);
    chk("F10 row9", row_data, 8'hFE);
    chk("F10 stop", {7'd0, stop_key}, 8'h01);
    row_sel = 4'hC;
    cycles(1);
    chk("row 0Ch", row_data, 8'hFF);

    // three toggles on consecutive cycles: A, B applied, C dropped
    row_sel = 4'd2;
    send(8'h1C, 1'b0, 1'b1);
    send(8'h32, 1'b0, 1'b1);
    send(8'h21, 1'b0, 1'b1);
    cycles(10);
    chk("burst row2", row_data, 8'hF9);
    chk("burst ovf", {7'd0, kbd_overflow}, 8'h01);
    key(8'h1C, 1'b0, 1'b0);
    chk("burst ovf sticky", {7'd0, kbd_overflow}, 8'h01);

    // reset clears everything
    do_reset();
    cycles(1);
    chk("post-reset stop", {7'd0, stop_key}, 8'h00);
    chk("post-reset ovf", {7'd0, kbd_overflow}, 8'h00);
    for (int r = 0; r < 10; r++) begin
      row_sel = 4'(r);
      cycles(1);
      chk($sformatf("post-reset row %0d", r), row_data, 8'hFF);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
